mem_bus_arbiter: RTL

- Sequences and shares the single instruction/data memory bus between the fetch stage and the load/store stage.
- Decodes each request to the ROM or RAM region and drives chip selects, output_enable and write_enable for a fixed number of wait states.
- Returns read data with a one-cycle acknowledge pulse.
- Sits between the CPU core and the tristate ROM/RAM devices; it owns every bus control line.

---
 rtl/cpu_bus_pkg.sv | 26 ++
 rtl/mem_region_decode.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_bus_pkg
// Brief  : Shared types and constants for the CPU memory bus arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Which requester currently owns (or last owned) the bus
  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

  // Addresses strictly below this value belong to ROM
  localparam logic [31:0] ROM_LIMIT_DEFAULT = 32'h0000_1000;

endpackage
`default_nettype wire

// File: rtl/mem_region_decode.sv
`default_nettype none
// ============================================================================
// Module : mem_region_decode
// Brief  : Classifies a bus address as ROM (below ROM_LIMIT) or RAM.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_region_decode
  import cpu_bus_pkg::*;
#(
  parameter logic [31:0] ROM_LIMIT = ROM_LIMIT_DEFAULT
) (
  input  logic [31:0] addr_i,
  output logic        is_rom_o,
  output logic        is_ram_o
);

  // ROM_LIMIT itself is the first RAM address
  always_comb begin
    is_rom_o = (addr_i < ROM_LIMIT);
    is_ram_o = ~is_rom_o;
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_bus_arbiter
// Brief  : Round-robin fetch/data arbiter for a shared ROM/RAM bus with
//          fixed wait states and one-cycle acknowledge.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ROM_LIMIT   = ROM_LIMIT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic [63:0] dm_rdata,
  output logic        dm_ack,
  output logic        dm_err,
  output logic [31:0] bus_address,
  input  logic [63:0] bus_rdata,
  output logic [63:0] bus_wdata,
  output logic        bus_drive,
  output logic        rom_cs,
  output logic        ram_cs,
  output logic        output_enable,
  output logic        write_enable
);

  localparam int unsigned      CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);

  state_e             state_q, state_d;
  grant_e             grant_q, grant_d;
  grant_e             last_grant_q, last_grant_d;
  grant_e             w_pick;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [31:0]        if_data_q, if_data_d;
  logic [63:0]        dm_rdata_q, dm_rdata_d;
  logic               w_is_rom, w_is_ram;
  logic               w_access, w_done, w_ram_store;

  mem_region_decode #(
    .ROM_LIMIT (ROM_LIMIT)
  ) u_decode (
    .addr_i   (addr_q),
    .is_rom_o (w_is_rom),
    .is_ram_o (w_is_ram)
  );

  // State and transfer context registers; reset aborts any transfer in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_FETCH;
      last_grant_q <= GNT_DATA;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      if_data_q    <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      if_data_q    <= if_data_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  // Next-state: grant in IDLE, count wait states, capture read data on exit
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    if_data_d    = if_data_q;
    dm_rdata_d   = dm_rdata_q;
    // On a tie the requester that did not win last time gets the bus
    if (if_req && dm_req) begin
      w_pick = (last_grant_q == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    end else begin
      w_pick = if_req ? GNT_FETCH : GNT_DATA;
    end
    case (state_q)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          grant_d      = w_pick;
          last_grant_d = w_pick;
          cnt_d        = '0;
          state_d      = ST_ACCESS;
          if (w_pick == GNT_FETCH) begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end else begin
            addr_d  = dm_addr;
            we_d    = dm_we;
            wdata_d = dm_wdata;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          // Stores leave the load-data register untouched
          if (grant_q == GNT_FETCH) begin
            if_data_d = bus_rdata[31:0];
          end else if (!we_q) begin
            dm_rdata_d = bus_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus strobes exist only during ACCESS; a store to ROM asserts nothing
  always_comb begin
    w_access      = (state_q == ST_ACCESS);
    w_done        = (state_q == ST_DONE);
    w_ram_store   = w_access & we_q & w_is_ram;
    bus_address   = w_access ? addr_q : 32'h0;
    rom_cs        = w_access & w_is_rom & ~we_q;
    ram_cs        = w_access & w_is_ram;
    output_enable = w_access & ~we_q;
    write_enable  = w_ram_store;
    bus_drive     = w_ram_store;
    bus_wdata     = w_ram_store ? wdata_q : 64'h0;
    if_ack        = w_done & (grant_q == GNT_FETCH);
    dm_ack        = w_done & (grant_q == GNT_DATA);
    dm_err        = w_done & (grant_q == GNT_DATA) & we_q & w_is_rom;
    if_data       = if_data_q;
    dm_rdata      = dm_rdata_q;
  end

endmodule
`default_nettype wire
